ppt_multi_pulse_gen: RTL and testbench

- Parametrised N-channel successor of the single-channel PPT pulse-train core.
- Each channel has its own period, width, pulse count, start delay and output polarity, plus free-running mode, abort, synchronised start and per-channel progress/done reporting.
- Sits behind the I2C register file. Config buses and run bits come from the register file; status goes back to its read mux.
- pulse_out drives the uo_out pins.

---
 rtl/ppt_multi_pulse_gen_if.sv | 30 +++
 rtl/ppt_multi_pulse_gen.sv | 170 +++++++++++++++++
 tb/tb_ppt_multi_pulse_gen.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppt_multi_pulse_gen_if.sv
// Register-file side bundle for the multi-channel pulse-train core: config and run bits in, status out.
// The core takes the slave modport; the register file takes the master modport.
interface ppt_multi_pulse_gen_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int DLY_W    = 16
);
    logic [CHANNELS-1:0]       run;
    logic                      sync_start;
    logic [CHANNELS*CNT_W-1:0] period;
    logic [CHANNELS*CNT_W-1:0] width;
    logic [CHANNELS*CNT_W-1:0] count;
    logic [CHANNELS*DLY_W-1:0] delay;
    logic [CHANNELS-1:0]       polarity;
    logic [CHANNELS-1:0]       pulse_out;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;
    logic [CHANNELS-1:0]       err;
    logic [CHANNELS*CNT_W-1:0] count_done;

    modport master (
        output run, sync_start, period, width, count, delay, polarity,
        input  pulse_out, busy, done, err, count_done
    );

    modport slave (
        input  run, sync_start, period, width, count, delay, polarity,
        output pulse_out, busy, done, err, count_done
    );
endinterface

// File: rtl/ppt_multi_pulse_gen.sv
// N independent pulse-train channels with start delay, polarity, abort and shared synchronised start.
// Latency: first active output cycle is registered one edge after the start edge plus the delay.
// No backpressure: config is shadowed at start, status is continuously valid.
module ppt_multi_pulse_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int DLY_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    ppt_multi_pulse_gen_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_INACTIVE,
        S_DONE
    } state_t;

    logic [CHANNELS-1:0]       pulse_vec;
    logic [CHANNELS-1:0]       busy_vec;
    logic [CHANNELS-1:0]       done_vec;
    logic [CHANNELS-1:0]       err_vec;
    logic [CHANNELS*CNT_W-1:0] cd_vec;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] per_in, wid_in, cnt_in;
        logic [DLY_W-1:0] dly_in;
        logic             run_in, pol_in;

        state_t           state_q, state_n;
        logic [CNT_W-1:0] phase_q, phase_n;
        logic [DLY_W-1:0] dly_q, dly_n;
        logic [CNT_W-1:0] per_s, per_n, wid_s, wid_n, cnt_s, cnt_n;
        logic             pol_s, pol_n;
        logic             out_q, out_n;
        logic             done_q, done_n, err_q, err_n;
        logic [CNT_W-1:0] cd_q, cd_n;
        logic             run_prev_q;

        logic             start;
        logic [CNT_W-1:0] act_len;
        logic [CNT_W-1:0] cd_inc;
        logic             period_end;
        logic [CNT_W-1:0] emit_idx;
        logic             idle_like;

        assign per_in = bus.period[c*CNT_W +: CNT_W];
        assign wid_in = bus.width[c*CNT_W +: CNT_W];
        assign cnt_in = bus.count[c*CNT_W +: CNT_W];
        assign dly_in = bus.delay[c*DLY_W +: DLY_W];
        assign run_in = bus.run[c];
        assign pol_in = bus.polarity[c];

        assign start      = run_in && (!run_prev_q || bus.sync_start);
        assign act_len    = (wid_s < per_s) ? wid_s : per_s;
        assign cd_inc     = (cd_q == '1) ? cd_q : cd_q + 1'b1;
        // phase_q counts cycles already emitted in this period; reaching per_s means the period just ended
        assign period_end = (phase_q == per_s);
        assign emit_idx   = period_end ? '0 : phase_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= S_IDLE;
                phase_q    <= '0;
                dly_q      <= '0;
                per_s      <= '0;
                wid_s      <= '0;
                cnt_s      <= '0;
                pol_s      <= 1'b0;
                out_q      <= 1'b0;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                cd_q       <= '0;
                // a run level held through reset must not look like a fresh rising edge
                run_prev_q <= run_in;
            end else begin
                state_q    <= state_n;
                phase_q    <= phase_n;
                dly_q      <= dly_n;
                per_s      <= per_n;
                wid_s      <= wid_n;
                cnt_s      <= cnt_n;
                pol_s      <= pol_n;
                out_q      <= out_n;
                done_q     <= done_n;
                err_q      <= err_n;
                cd_q       <= cd_n;
                run_prev_q <= run_in;
            end
        end

        always_comb begin
            state_n = state_q;
            phase_n = phase_q;
            dly_n   = dly_q;
            per_n   = per_s;
            wid_n   = wid_s;
            cnt_n   = cnt_s;
            pol_n   = pol_s;
            out_n   = out_q;
            done_n  = done_q;
            err_n   = err_q;
            cd_n    = cd_q;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        per_n   = per_in;
                        wid_n   = wid_in;
                        cnt_n   = cnt_in;
                        pol_n   = pol_in;
                        dly_n   = dly_in;
                        phase_n = '0;
                        out_n   = pol_in;
                        done_n  = 1'b0;
                        cd_n    = '0;
                        if (per_in == '0) begin
                            err_n   = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            err_n   = 1'b0;
                            state_n = (dly_in != '0) ? S_DELAY : S_ACTIVE;
                        end
                    end
                end
                S_DELAY: begin
                    if (!run_in) begin
                        state_n = S_IDLE;
                    end else begin
                        dly_n = dly_q - 1'b1;
                        if (dly_q == DLY_W'(1)) state_n = S_ACTIVE;
                    end
                end
                S_ACTIVE, S_INACTIVE: begin
                    if (period_end) cd_n = cd_inc;
                    // completion wins over a simultaneous abort
                    if (period_end && cnt_s != '0 && cd_inc == cnt_s) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        out_n   = pol_s;
                    end else if (!run_in) begin
                        state_n = S_IDLE;
                        out_n   = pol_s;
                    end else begin
                        out_n   = (emit_idx < act_len) ? ~pol_s : pol_s;
                        state_n = (emit_idx < act_len) ? S_ACTIVE : S_INACTIVE;
                        phase_n = emit_idx + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        assign idle_like            = (state_q == S_IDLE) || (state_q == S_DONE);
        assign pulse_vec[c]         = idle_like ? pol_in : out_q;
        assign busy_vec[c]          = !idle_like;
        assign done_vec[c]          = done_q;
        assign err_vec[c]           = err_q;
        assign cd_vec[c*CNT_W +: CNT_W] = cd_q;
    end

    assign bus.pulse_out  = pulse_vec;
    assign bus.busy       = busy_vec;
    assign bus.done       = done_vec;
    assign bus.err        = err_vec;
    assign bus.count_done = cd_vec;

endmodule

// File: tb/tb_ppt_multi_pulse_gen.sv
// Self-checking bench: directed scenarios plus randomized traffic against a time-arithmetic reference model.
module tb_ppt_multi_pulse_gen;
    localparam int CH   = 4;
    localparam int CW   = 16;
    localparam int DW   = 16;
    localparam int MAXC = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    ppt_multi_pulse_gen_if #(.CHANNELS(CH), .CNT_W(CW), .DLY_W(DW)) bus ();

    ppt_multi_pulse_gen #(.CHANNELS(CH), .CNT_W(CW), .DLY_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 running (delay or pulsing), 2 done.
    int m_mode[CH], m_ts[CH], m_p[CH], m_w[CH], m_n[CH], m_d[CH], m_cd[CH];
    bit m_pol[CH], m_done[CH], m_err[CH], m_prev[CH];

    function automatic int exp_cd1(int c);
        int rel, v;
        if (m_mode[c] != 1) return m_cd[c];
        rel = cyc - (m_ts[c] + 1 + m_d[c]);
        if (rel < 0) return 0;
        v = rel / m_p[c];
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic exp_po(int c);
        int rel, a;
        if (m_mode[c] != 1) return bus.polarity[c];
        rel = cyc - (m_ts[c] + 1 + m_d[c]);
        if (rel < 0) return m_pol[c];
        a = (m_w[c] < m_p[c]) ? m_w[c] : m_p[c];
        return ((rel % m_p[c]) < a) ? ~m_pol[c] : m_pol[c];
    endfunction

    function automatic logic [4*CH-1:0] exp_flags();
        logic [CH-1:0] po, bz, dn, er;
        for (int c = 0; c < CH; c++) begin
            po[c] = exp_po(c);
            bz[c] = (m_mode[c] == 1);
            dn[c] = m_done[c];
            er[c] = m_err[c];
        end
        return {po, bz, dn, er};
    endfunction

    function automatic logic [CH*CW-1:0] exp_cdv();
        logic [CH*CW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*CW +: CW] = CW'(exp_cd1(c));
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit r, trig;
        int cdv;
        cyc = cyc + 1;
        for (int c = 0; c < CH; c++) begin
            r = bus.run[c];
            if (rst) begin
                m_mode[c] = 0; m_done[c] = 0; m_err[c] = 0; m_cd[c] = 0; m_prev[c] = r;
            end else begin
                trig = r && (!m_prev[c] || bus.sync_start);
                if (m_mode[c] == 1) begin
                    cdv = exp_cd1(c);
                    if (m_n[c] != 0 && cdv == m_n[c]) begin
                        m_mode[c] = 2; m_done[c] = 1; m_cd[c] = cdv;
                    end else if (!r) begin
                        m_mode[c] = 0; m_cd[c] = cdv;
                    end
                end else if (trig) begin
                    m_p[c]   = int'(bus.period[c*CW +: CW]);
                    m_w[c]   = int'(bus.width[c*CW +: CW]);
                    m_n[c]   = int'(bus.count[c*CW +: CW]);
                    m_d[c]   = int'(bus.delay[c*DW +: DW]);
                    m_pol[c] = bus.polarity[c];
                    m_done[c] = 0; m_cd[c] = 0;
                    if (m_p[c] == 0) begin
                        m_err[c] = 1; m_mode[c] = 0;
                    end else begin
                        m_err[c] = 0; m_mode[c] = 1; m_ts[c] = cyc;
                    end
                end
                m_prev[c] = r;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(int c, int p, int w, int n, int d, bit pol);
        bus.period[c*CW +: CW] = CW'(p);
        bus.width[c*CW +: CW]  = CW'(w);
        bus.count[c*CW +: CW]  = CW'(n);
        bus.delay[c*DW +: DW]  = DW'(d);
        bus.polarity[c]        = pol;
    endtask

    task automatic test_reset();
        for (int c = 0; c < CH; c++) set_cfg(c, 10, 2, 1, 0, 1'b0);
        bus.polarity = 4'b0010;
        bus.run = 4'hF;
        bus.sync_start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.pulse_out !== 4'b0010) begin failures++; $display("FAIL reset_pulse_out got=%b exp=0010", bus.pulse_out); end
        checks++; if (bus.busy !== 4'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0000", bus.busy); end
        checks++; if (bus.done !== 4'b0 || bus.err !== 4'b0) begin failures++; $display("FAIL reset_done_err got=%b/%b exp=0", bus.done, bus.err); end
        checks++; if (bus.count_done !== '0) begin failures++; $display("FAIL reset_count_done got=%h exp=0", bus.count_done); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.busy !== 4'b0) begin failures++; $display("FAIL reset_no_start cyc=%0d busy=%b exp=0000", cyc, bus.busy); end
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
        end
        bus.run = 4'h0;
        tick();
    endtask

    task automatic test_basic_train();
        int t0, np;
        bit prev;
        np = 0; prev = bus.pulse_out[0];
        set_cfg(0, 32, 4, 50, 0, 1'b0);
        bus.run[0] = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 1700; i++) begin
            if (i != 0) tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
            checks++; if (bus.count_done !== exp_cdv()) begin failures++; $display("FAIL basic_cd cyc=%0d got=%h exp=%h", cyc, bus.count_done, exp_cdv()); end
            if (bus.pulse_out[0] && !prev) np++;
            prev = bus.pulse_out[0];
            if (cyc == t0 + 1) begin
                checks++; if (bus.pulse_out[0] !== 1'b1) begin failures++; $display("FAIL basic_first_pulse got=%b exp=1", bus.pulse_out[0]); end
            end
            if (cyc == t0 + 5) begin
                checks++; if (bus.pulse_out[0] !== 1'b0) begin failures++; $display("FAIL basic_width got=%b exp=0", bus.pulse_out[0]); end
            end
            if (cyc == t0 + 1600) begin
                checks++; if (bus.done[0] !== 1'b0 || bus.busy[0] !== 1'b1) begin failures++; $display("FAIL basic_pre_done done=%b busy=%b exp=0/1", bus.done[0], bus.busy[0]); end
            end
            if (cyc == t0 + 1601) begin
                checks++; if (bus.done[0] !== 1'b1 || bus.busy[0] !== 1'b0) begin failures++; $display("FAIL basic_done done=%b busy=%b exp=1/0", bus.done[0], bus.busy[0]); end
                checks++; if (bus.count_done[0 +: CW] !== 16'd50) begin failures++; $display("FAIL basic_count_done got=%0d exp=50", bus.count_done[0 +: CW]); end
            end
        end
        checks++; if (np != 50) begin failures++; $display("FAIL basic_pulse_count got=%0d exp=50", np); end
        bus.run[0] = 1'b0;
        tick();
    endtask

    task automatic test_delay_sync();
        int t0;
        set_cfg(1, 0, 3, 2, 10, 1'b0);
        set_cfg(2, 0, 3, 2, 0, 1'b0);
        bus.run[1] = 1'b1;
        bus.run[2] = 1'b1;
        tick();
        tick();
        checks++; if (bus.err[2:1] !== 2'b11 || bus.busy[2:1] !== 2'b00) begin failures++; $display("FAIL sync_err_arm err=%b busy=%b exp=11/00", bus.err[2:1], bus.busy[2:1]); end
        bus.period[1*CW +: CW] = 16'd8;
        bus.period[2*CW +: CW] = 16'd8;
        bus.sync_start = 1'b1;
        tick();
        t0 = cyc;
        bus.sync_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i != 0) tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL sync_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
            checks++; if (bus.count_done !== exp_cdv()) begin failures++; $display("FAIL sync_cd cyc=%0d got=%h exp=%h", cyc, bus.count_done, exp_cdv()); end
            if (cyc == t0) begin
                checks++; if (bus.err[2:1] !== 2'b00 || bus.busy[2:1] !== 2'b11) begin failures++; $display("FAIL sync_start err=%b busy=%b exp=00/11", bus.err[2:1], bus.busy[2:1]); end
            end
            if (cyc == t0 + 1) begin
                checks++; if (bus.pulse_out[2:1] !== 2'b10) begin failures++; $display("FAIL sync_ch2_first got=%b exp=10", bus.pulse_out[2:1]); end
            end
            if (cyc == t0 + 10) begin
                checks++; if (bus.pulse_out[1] !== 1'b0) begin failures++; $display("FAIL sync_ch1_delay got=%b exp=0", bus.pulse_out[1]); end
            end
            if (cyc == t0 + 11) begin
                checks++; if (bus.pulse_out[1] !== 1'b1) begin failures++; $display("FAIL sync_ch1_first got=%b exp=1", bus.pulse_out[1]); end
            end
            if (cyc == t0 + 16 || cyc == t0 + 17) begin
                checks++; if (bus.done[2] !== (cyc == t0 + 17)) begin failures++; $display("FAIL sync_ch2_done cyc=%0d got=%b", cyc - t0, bus.done[2]); end
            end
            if (cyc == t0 + 26 || cyc == t0 + 27) begin
                checks++; if (bus.done[1] !== (cyc == t0 + 27)) begin failures++; $display("FAIL sync_ch1_done cyc=%0d got=%b", cyc - t0, bus.done[1]); end
            end
        end
        bus.run[2:1] = 2'b00;
        tick();
    endtask

    task automatic test_abort_and_err();
        int t0;
        set_cfg(3, 5, 7, 0, 0, 1'b0);
        bus.run[3] = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 25; i++) begin
            if (i != 0) tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL abort_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
            checks++; if (bus.count_done !== exp_cdv()) begin failures++; $display("FAIL abort_cd cyc=%0d got=%h exp=%h", cyc, bus.count_done, exp_cdv()); end
            if (cyc >= t0 + 1 && cyc <= t0 + 20) begin
                checks++; if (bus.pulse_out[3] !== 1'b1) begin failures++; $display("FAIL abort_full_width cyc=%0d got=%b exp=1", cyc - t0, bus.pulse_out[3]); end
            end
            if (cyc == t0 + 20) bus.run[3] = 1'b0;
            if (cyc == t0 + 21) begin
                checks++; if (bus.pulse_out[3] !== 1'b0 || bus.done[3] !== 1'b0 || bus.busy[3] !== 1'b0) begin failures++; $display("FAIL abort_idle po=%b done=%b busy=%b exp=0/0/0", bus.pulse_out[3], bus.done[3], bus.busy[3]); end
                checks++; if (bus.count_done[3*CW +: CW] !== 16'd4) begin failures++; $display("FAIL abort_count_done got=%0d exp=4", bus.count_done[3*CW +: CW]); end
            end
        end
        set_cfg(3, 0, 2, 2, 0, 1'b0);
        bus.run[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.err[3] !== 1'b1 || bus.busy[3] !== 1'b0 || bus.pulse_out[3] !== 1'b0) begin failures++; $display("FAIL err_period0 cyc=%0d err=%b busy=%b po=%b exp=1/0/0", cyc, bus.err[3], bus.busy[3], bus.pulse_out[3]); end
        end
        bus.run[3] = 1'b0;
        tick();
        bus.period[3*CW +: CW] = 16'd5;
        bus.run[3] = 1'b1;
        tick();
        checks++; if (bus.err[3] !== 1'b0 || bus.busy[3] !== 1'b1) begin failures++; $display("FAIL err_clear err=%b busy=%b exp=0/1", bus.err[3], bus.busy[3]); end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL err_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
        end
        bus.run[3] = 1'b0;
        tick();
    endtask

    task automatic test_shadow_polarity();
        int t0;
        set_cfg(0, 10, 2, 3, 0, 1'b1);
        bus.run[0] = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            if (i != 0) tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL shadow_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
            checks++; if (bus.count_done !== exp_cdv()) begin failures++; $display("FAIL shadow_cd cyc=%0d got=%h exp=%h", cyc, bus.count_done, exp_cdv()); end
            if (cyc == t0 + 5) bus.period[0 +: CW] = 16'd100;
            if (cyc == t0 + 2 || cyc == t0 + 11) begin
                checks++; if (bus.pulse_out[0] !== 1'b0) begin failures++; $display("FAIL shadow_active_low cyc=%0d got=%b exp=0", cyc - t0, bus.pulse_out[0]); end
            end
            if (cyc == t0 + 3 || cyc == t0 + 13) begin
                checks++; if (bus.pulse_out[0] !== 1'b1) begin failures++; $display("FAIL shadow_inactive cyc=%0d got=%b exp=1", cyc - t0, bus.pulse_out[0]); end
            end
            if (cyc == t0 + 30 || cyc == t0 + 31) begin
                checks++; if (bus.done[0] !== (cyc == t0 + 31)) begin failures++; $display("FAIL shadow_done cyc=%0d got=%b", cyc - t0, bus.done[0]); end
            end
        end
        bus.run[0] = 1'b0;
        tick();
        bus.run[0] = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 110; i++) begin
            tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL restart_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
            if (cyc == t0 + 100 || cyc == t0 + 101) begin
                checks++; if (bus.pulse_out[0] !== (cyc == t0 + 100)) begin failures++; $display("FAIL restart_period100 cyc=%0d got=%b", cyc - t0, bus.pulse_out[0]); end
            end
        end
        bus.run[0] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            tick();
            checks++; if ({bus.pulse_out, bus.busy, bus.done, bus.err} !== exp_flags()) begin failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, {bus.pulse_out, bus.busy, bus.done, bus.err}, exp_flags()); end
            checks++; if (bus.count_done !== exp_cdv()) begin failures++; $display("FAIL random_cd cyc=%0d got=%h exp=%h", cyc, bus.count_done, exp_cdv()); end
            rst = ($urandom_range(0, 599) == 0);
            bus.sync_start = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 39) == 0) bus.run[c] = ~bus.run[c];
                if ($urandom_range(0, 29) == 0)
                    set_cfg(c, $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 4),
                            $urandom_range(0, 5), 1'($urandom_range(0, 1)));
            end
        end
        rst = 1'b0;
        bus.sync_start = 1'b0;
    endtask

    initial begin
        bus.run = '0;
        bus.sync_start = 1'b0;
        bus.period = '0;
        bus.width = '0;
        bus.count = '0;
        bus.delay = '0;
        bus.polarity = '0;
        test_reset();
        test_basic_train();
        test_delay_sync();
        test_abort_and_err();
        test_shadow_polarity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
